load_store_unit: RTL



---
 rtl/load_store_unit.sv | 229 ++++++++++++++++++++++
 1 files changed

// File: rtl/load_store_unit.sv
// RV32I load/store unit: byte-addressed LB/LH/LW/LBU/LHU/SB/SH/SW onto a word memory.
// Optional build macro LSU_RANGE_CHECK_EN turns out-of-range word indices into errors instead of wrapping.
module load_store_unit #(
  parameter int XLEN      = 32,
  parameter int MEM_WORDS = 64
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            req_valid_i,
  output logic            req_ready_o,
  input  logic            req_we_i,
  input  logic [2:0]      req_funct3_i,
  input  logic [XLEN-1:0] req_addr_i,
  input  logic [XLEN-1:0] req_wdata_i,
  output logic            resp_valid_o,
  output logic [XLEN-1:0] resp_rdata_o,
  output logic            resp_err_o,
  output logic [XLEN-1:0] mem_addr_o,
  output logic            mem_we_o,
  output logic [XLEN-1:0] mem_wdata_o,
  input  logic [XLEN-1:0] mem_rdata_i
);

  localparam int AW = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {IDLE, ACCESS, MERGE, RESP} state_e;

  state_e          state_q, state_d;
  logic            we_q, we_d;
  logic [2:0]      f3_q, f3_d;
  logic [1:0]      lane_q, lane_d;
  logic [XLEN-1:0] wdata_q, wdata_d;
  logic [XLEN-1:0] mem_addr_q, mem_addr_d;
  logic            mem_we_q, mem_we_d;
  logic [XLEN-1:0] mem_wdata_q, mem_wdata_d;
  logic            resp_valid_q, resp_valid_d;
  logic [XLEN-1:0] resp_rdata_q, resp_rdata_d;
  logic            resp_err_q, resp_err_d;
  logic            misalign_s, illegal_s, range_s, req_err_s;

  // Pick the addressed byte/half out of a word and sign- or zero-extend it.
  function automatic logic [XLEN-1:0] load_extend(input logic [2:0] f3, input logic [1:0] lane,
                                                  input logic [XLEN-1:0] word);
    logic [7:0]  b;
    logic [15:0] h;
    case (lane)
      2'd0:    b = word[7:0];
      2'd1:    b = word[15:8];
      2'd2:    b = word[23:16];
      default: b = word[31:24];
    endcase
    h = lane[1] ? word[31:16] : word[15:0];
    case (f3)
      F3_B:    return {{(XLEN-8){b[7]}}, b};
      F3_H:    return {{(XLEN-16){h[15]}}, h};
      F3_BU:   return {{(XLEN-8){1'b0}}, b};
      F3_HU:   return {{(XLEN-16){1'b0}}, h};
      default: return word;
    endcase
  endfunction

  // Overlay the low byte/half of the store data onto the old memory word.
  function automatic logic [XLEN-1:0] store_merge(input logic [2:0] f3, input logic [1:0] lane,
                                                  input logic [XLEN-1:0] old_word,
                                                  input logic [XLEN-1:0] wdata);
    logic [XLEN-1:0] w;
    w = old_word;
    case (f3)
      F3_B: begin
        case (lane)
          2'd0:    w[7:0]   = wdata[7:0];
          2'd1:    w[15:8]  = wdata[7:0];
          2'd2:    w[23:16] = wdata[7:0];
          default: w[31:24] = wdata[7:0];
        endcase
      end
      F3_H: begin
        if (lane[1]) w[31:16] = wdata[15:0];
        else         w[15:0]  = wdata[15:0];
      end
      default: w = wdata;
    endcase
    return w;
  endfunction

  // Request legality: alignment, funct3 legality and word-index range.
  always_comb begin
    misalign_s = 1'b0;
    illegal_s  = 1'b0;
    case (req_funct3_i)
      F3_B:    misalign_s = 1'b0;
      F3_H:    misalign_s = req_addr_i[0];
      F3_W:    misalign_s = |req_addr_i[1:0];
      F3_BU:   illegal_s  = req_we_i;
      F3_HU: begin
        illegal_s  = req_we_i;
        misalign_s = req_addr_i[0];
      end
      default: illegal_s = 1'b1;
    endcase
  end

`ifdef LSU_RANGE_CHECK_EN
  localparam logic [XLEN-3:0] MEM_WORDS_W = (XLEN-2)'(MEM_WORDS);
  assign range_s = (req_addr_i[XLEN-1:2] >= MEM_WORDS_W);
`else
  // Upper index bits are dropped so the index wraps modulo the memory size.
  logic unused_addr_s;
  assign unused_addr_s = ^req_addr_i[XLEN-1:AW+2];
  assign range_s       = 1'b0;
`endif

  assign req_err_s = misalign_s | illegal_s | range_s;

  // Next-state and next-output logic.
  always_comb begin
    state_d      = state_q;
    we_d         = we_q;
    f3_d         = f3_q;
    lane_d       = lane_q;
    wdata_d      = wdata_q;
    mem_addr_d   = mem_addr_q;
    mem_we_d     = 1'b0;
    mem_wdata_d  = mem_wdata_q;
    resp_valid_d = 1'b0;
    resp_rdata_d = resp_rdata_q;
    resp_err_d   = resp_err_q;
    case (state_q)
      IDLE: begin
        if (req_valid_i) begin
          we_d    = req_we_i;
          f3_d    = req_funct3_i;
          lane_d  = req_addr_i[1:0];
          wdata_d = req_wdata_i;
          if (req_err_s) begin
            state_d      = RESP;
            resp_valid_d = 1'b1;
            resp_err_d   = 1'b1;
            resp_rdata_d = '0;
          end else begin
            state_d    = ACCESS;
            mem_addr_d = {{(XLEN-AW){1'b0}}, req_addr_i[AW+1:2]};
            // A full-word store writes during ACCESS, so its strobe is set up here.
            if (req_we_i && (req_funct3_i == F3_W)) begin
              mem_we_d    = 1'b1;
              mem_wdata_d = req_wdata_i;
            end else begin
              mem_we_d    = 1'b0;
            end
          end
        end else begin
          state_d = IDLE;
        end
      end
      ACCESS: begin
        if (!we_q) begin
          state_d      = RESP;
          resp_valid_d = 1'b1;
          resp_err_d   = 1'b0;
          resp_rdata_d = load_extend(f3_q, lane_q, mem_rdata_i);
        end else if (f3_q == F3_W) begin
          state_d      = RESP;
          resp_valid_d = 1'b1;
          resp_err_d   = 1'b0;
          resp_rdata_d = '0;
        end else begin
          state_d     = MERGE;
          mem_we_d    = 1'b1;
          mem_wdata_d = store_merge(f3_q, lane_q, mem_rdata_i, wdata_q);
        end
      end
      MERGE: begin
        state_d      = RESP;
        resp_valid_d = 1'b1;
        resp_err_d   = 1'b0;
        resp_rdata_d = '0;
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= IDLE;
    else         state_q <= state_d;
  end

  // Request capture, memory-side and response registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      we_q         <= 1'b0;
      f3_q         <= 3'b000;
      lane_q       <= 2'b00;
      wdata_q      <= '0;
      mem_addr_q   <= '0;
      mem_we_q     <= 1'b0;
      mem_wdata_q  <= '0;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= '0;
      resp_err_q   <= 1'b0;
    end else begin
      we_q         <= we_d;
      f3_q         <= f3_d;
      lane_q       <= lane_d;
      wdata_q      <= wdata_d;
      mem_addr_q   <= mem_addr_d;
      mem_we_q     <= mem_we_d;
      mem_wdata_q  <= mem_wdata_d;
      resp_valid_q <= resp_valid_d;
      resp_rdata_q <= resp_rdata_d;
      resp_err_q   <= resp_err_d;
    end
  end

  assign req_ready_o  = (state_q == IDLE);
  assign resp_valid_o = resp_valid_q;
  assign resp_rdata_o = resp_rdata_q;
  assign resp_err_o   = resp_err_q;
  assign mem_addr_o   = mem_addr_q;
  assign mem_we_o     = mem_we_q;
  assign mem_wdata_o  = mem_wdata_q;

endmodule
